// File: rtl/mysystem_pio_pkg.sv
// -----------------------------------------------------------------------------
// mysystem_pio_pkg
// Shared definitions for the PIO poller: FSM state encoding, counter width,
// default stall limit, Avalon-MM field widths and the debug view of the FSM.
// -----------------------------------------------------------------------------
package mysystem_pio_pkg;

  // Width of the interval counter and of the stall counter.
  localparam int CNT_W = 24;

  // Default number of waitrequest cycles tolerated on one read.
  localparam int WAIT_MAX_DEF = 255;

  // Avalon-MM field widths.
  localparam int ADDR_W     = 2;
  localparam int AVM_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // waiting for the next interval tick
    ST_READ = 2'd1,  // avm_read held until accepted or stall limit hit
    ST_LAT  = 2'd2,  // readdata valid this cycle; sample loads here
    ST_CAPT = 2'd3   // sample_valid / changed pulse
  } poll_state_e;

  // Debug view of the poller FSM.
  typedef struct packed {
    poll_state_e       state;
    logic [CNT_W-1:0]  stall_cnt;
    logic              first_pending;
  } poll_dbg_t;

  // Truncate a parameter value to counter width.
  function automatic logic [CNT_W-1:0] to_cnt(input int unsigned v);
    return v[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/mysystem_pio_poller_if.sv
// -----------------------------------------------------------------------------
// mysystem_pio_poller_if
// Avalon-MM read-only master bundle used by the PIO poller.
//   avm_address     master -> slave  word address
//   avm_read        master -> slave  read request
//   avm_waitrequest slave  -> master stall
//   avm_readdata    slave  -> master read data (fixed latency 1)
//
// Handshake: avm_read acts as "valid" and !avm_waitrequest as "ready". A read
// is accepted on a rising edge where avm_read=1 and avm_waitrequest=0; until
// then the master holds avm_read and avm_address stable. avm_readdata is valid
// exactly one cycle after the accepting edge.
// -----------------------------------------------------------------------------
interface mysystem_pio_poller_if;
  import mysystem_pio_pkg::*;

  logic [ADDR_W-1:0]     avm_address;
  logic                  avm_read;
  logic                  avm_waitrequest;
  logic [AVM_DATA_W-1:0] avm_readdata;

  modport master (
    output avm_address,
    output avm_read,
    input  avm_waitrequest,
    input  avm_readdata
  );

  modport slave (
    input  avm_address,
    input  avm_read,
    output avm_waitrequest,
    output avm_readdata
  );

endinterface

// File: rtl/mysystem_pio_interval.sv
// -----------------------------------------------------------------------------
// mysystem_pio_interval
// Enable-gated interval counter. Counts 0..POLL_DIV-1 while enable_i is high,
// holds while low, and produces a 1-cycle tick_o on the cycle the count sits
// at POLL_DIV-1 with enable_i high; the count clears on that same edge.
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-high reset (count -> 0)
//   enable_i  counting permitted
//   tick_o    interval expiry pulse (combinational from the count)
// -----------------------------------------------------------------------------
module mysystem_pio_interval
  import mysystem_pio_pkg::*;
#(
  parameter int unsigned POLL_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable_i,
  output logic tick_o
);

  localparam logic [CNT_W-1:0] LAST = to_cnt(POLL_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             tick;

  // The tick is qualified by enable so a count frozen at LAST does not fire
  // repeatedly while polling is disabled.
  always_comb begin
    tick  = enable_i && (cnt_q == LAST);
    cnt_d = cnt_q;
    if (tick) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = tick;

endmodule

// File: rtl/mysystem_pio_poller.sv
// -----------------------------------------------------------------------------
// mysystem_pio_poller
// Periodically reads one Avalon-MM word and publishes its low DATA_W bits.
// Every POLL_DIV enabled cycles a single read of RD_ADDR is issued; the value
// is captured one cycle after acceptance and announced with a 1-cycle
// sample_valid pulse, plus changed when it differs from the previous sample
// (always on the first capture after reset). A read stalled for WAIT_MAX
// waitrequest cycles is abandoned and sets the sticky timeout flag.
// Ports:
//   clk           rising-edge clock
//   reset         asynchronous active-high reset
//   enable        polling permitted while high
//   avm           Avalon-MM master (address, read, waitrequest, readdata)
//   sample        last captured avm_readdata[DATA_W-1:0]
//   sample_valid  1-cycle pulse on each capture
//   changed       1-cycle pulse with sample_valid when the value changed
//   timeout       sticky stalled-read flag, cleared only by reset
//   dbg_o         FSM state, stall count and first-capture flag
// -----------------------------------------------------------------------------
module mysystem_pio_poller
  import mysystem_pio_pkg::*;
#(
  parameter int unsigned DATA_W   = 10,
  parameter int unsigned POLL_DIV = 50000,
  parameter int unsigned RD_ADDR  = 0,
  parameter int unsigned WAIT_MAX = WAIT_MAX_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  mysystem_pio_poller_if.master        avm,
  output logic [DATA_W-1:0]            sample,
  output logic                         sample_valid,
  output logic                         changed,
  output logic                         timeout,
  output poll_dbg_t                    dbg_o
);

  localparam logic [ADDR_W-1:0] RD_ADDR_C = RD_ADDR[ADDR_W-1:0];
  // Stall count value seen on the WAIT_MAX-th consecutive stall cycle.
  localparam logic [CNT_W-1:0]  WAIT_LAST = to_cnt(WAIT_MAX - 1);

  poll_state_e       state_q;
  logic [CNT_W-1:0]  stall_q;
  logic              read_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] sample_q;
  logic              valid_q;
  logic              changed_q;
  logic              timeout_q;
  logic              first_q;

  logic              tick;
  logic [DATA_W-1:0] rd_field;

  // Interval timer runs in every state; ticks outside IDLE are dropped.
  mysystem_pio_interval #(
    .POLL_DIV (POLL_DIV)
  ) u_interval (
    .clk      (clk),
    .reset    (reset),
    .enable_i (enable),
    .tick_o   (tick)
  );

  assign rd_field = avm.avm_readdata[DATA_W-1:0];

  // Only the low DATA_W bits of readdata are meaningful here.
  generate
    if (DATA_W < AVM_DATA_W) begin : g_upper
      logic unused_upper;
      assign unused_upper = ^avm.avm_readdata[AVM_DATA_W-1:DATA_W];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      stall_q   <= '0;
      read_q    <= 1'b0;
      addr_q    <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
      timeout_q <= 1'b0;
      first_q   <= 1'b1;
    end else begin
      // Pulses default low; they are raised only on the LAT -> CAPT edge.
      valid_q   <= 1'b0;
      changed_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (tick) begin
            state_q <= ST_READ;
            read_q  <= 1'b1;
            addr_q  <= RD_ADDR_C;
            stall_q <= '0;
          end
        end
        ST_READ: begin
          // Enable is not consulted: an issued read is held until accepted.
          if (!avm.avm_waitrequest) begin
            state_q <= ST_LAT;
            read_q  <= 1'b0;
            addr_q  <= '0;
          end else if (stall_q == WAIT_LAST) begin
            state_q   <= ST_IDLE;
            read_q    <= 1'b0;
            addr_q    <= '0;
            timeout_q <= 1'b1;
          end else begin
            stall_q <= stall_q + 1'b1;
          end
        end
        ST_LAT: begin
          // readdata is valid in this cycle; the pulses appear during CAPT.
          sample_q  <= rd_field;
          valid_q   <= 1'b1;
          changed_q <= first_q || (rd_field != sample_q);
          first_q   <= 1'b0;
          state_q   <= ST_CAPT;
        end
        ST_CAPT: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          read_q  <= 1'b0;
          addr_q  <= '0;
        end
      endcase
    end
  end

  assign avm.avm_read    = read_q;
  assign avm.avm_address = addr_q;
  assign sample          = sample_q;
  assign sample_valid    = valid_q;
  assign changed         = changed_q;
  assign timeout         = timeout_q;

  assign dbg_o.state         = state_q;
  assign dbg_o.stall_cnt     = stall_q;
  assign dbg_o.first_pending = first_q;

endmodule

// File: tb/tb_mysystem_pio_poller.sv
// -----------------------------------------------------------------------------
// tb_mysystem_pio_poller
// Directed bench for mysystem_pio_poller with POLL_DIV=8, RD_ADDR=2,
// WAIT_MAX=255. A transfer-level model predicts all outputs every cycle; a
// capture queue holds hand-computed {changed, sample} pairs; directed checks
// pin poll spacing, stall timing, timeout and reset behaviour.
// -----------------------------------------------------------------------------
module tb_mysystem_pio_poller;
  import mysystem_pio_pkg::*;

  localparam int DATA_W   = 10;
  localparam int POLL_DIV = 8;
  localparam int RD_ADDR  = 2;
  localparam int WAIT_MAX = 255;

  // ---------------- clock / reset ----------------
  logic clk    = 1'b0;
  logic reset  = 1'b1;
  logic enable = 1'b0;

  logic [DATA_W-1:0] sample;
  logic              sample_valid;
  logic              changed;
  logic              timeout;
  poll_dbg_t         dbg;

  mysystem_pio_poller_if avm_if();

  mysystem_pio_poller #(
    .DATA_W   (DATA_W),
    .POLL_DIV (POLL_DIV),
    .RD_ADDR  (RD_ADDR),
    .WAIT_MAX (WAIT_MAX)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .avm          (avm_if),
    .sample       (sample),
    .sample_valid (sample_valid),
    .changed      (changed),
    .timeout      (timeout),
    .dbg_o        (dbg)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int last_start = 0;

  // Expected captures, {changed, sample}, in order.
  logic [DATA_W:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- transfer-level model ----------------
  int              m_cnt;
  bit              m_rd;
  int              m_stall;
  int              m_age;    // -1 none, 0 data cycle, 1 announce cycle
  logic [DATA_W-1:0] m_sample;
  bit              m_chg;
  bit              m_to;
  bit              m_first;

  task automatic model_reset();
    m_cnt = 0; m_rd = 0; m_stall = 0; m_age = -1;
    m_sample = '0; m_chg = 0; m_to = 0; m_first = 1;
  endtask

  initial model_reset();

  logic [DATA_W+5:0] exp_vec;
  logic [DATA_W+5:0] act_vec;
  logic [DATA_W:0]   exp_cap;
  logic [DATA_W-1:0] lo;
  bit                tick;

  // Compare on the falling edge, then advance the model with the inputs the
  // next rising edge will see.
  always @(negedge clk) begin
    if (reset) model_reset();
    exp_vec = {m_rd, (m_rd ? 2'(RD_ADDR) : 2'd0), (m_age == 1), (m_age == 1) && m_chg,
               m_sample, m_to};
    act_vec = {avm_if.avm_read, avm_if.avm_address, sample_valid, changed, sample, timeout};
    checks++;
    if (act_vec !== exp_vec) begin
      errors++;
      $display("FAIL cycle_cmp cyc=%0d got %h expected %h", cyc, act_vec, exp_vec);
    end
    if (!reset && sample_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_capture cyc=%0d got %h expected none", cyc, {changed, sample});
      end else begin
        exp_cap = exp_q.pop_front();
        if ({changed, sample} !== exp_cap) begin
          errors++;
          $display("FAIL capture cyc=%0d got %h expected %h", cyc, {changed, sample}, exp_cap);
        end
      end
    end
    if (!reset) begin
      tick = enable && (m_cnt == POLL_DIV - 1);
      if (m_rd) begin
        if (!avm_if.avm_waitrequest) begin
          m_rd = 0; m_age = 0;
        end else begin
          m_stall++;
          if (m_stall == WAIT_MAX) begin
            m_rd = 0; m_to = 1;
          end
        end
      end else if (m_age == 0) begin
        lo = avm_if.avm_readdata[DATA_W-1:0];
        m_chg = m_first || (lo != m_sample);
        m_sample = lo; m_first = 0; m_age = 1;
      end else if (m_age == 1) begin
        m_age = -1;
      end else if (tick) begin
        m_rd = 1; m_stall = 0;
      end
      m_cnt = tick ? 0 : (enable ? m_cnt + 1 : m_cnt);
    end
  end

  // ---------------- driver tasks ----------------
  // Waits for avm_read and checks the spacing from the previous poll start.
  task automatic wait_read(input string name, input int exp_gap);
    bit seen = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #2;
      if (avm_if.avm_read) begin
        seen = 1;
        break;
      end
    end
    check({name, "_seen"}, 64'(seen), 64'd1);
    if (seen) check(name, 64'(cyc - last_start), 64'(exp_gap));
    last_start = cyc;
  endtask

  task automatic go_idle();
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic start_poll(input logic [31:0] d, input string name, input int gap);
    avm_if.avm_readdata    = d;
    avm_if.avm_waitrequest = 1'b0;
    wait_read(name, gap);
  endtask

  int hi;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    avm_if.avm_waitrequest = 1'b0;
    avm_if.avm_readdata    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_read",    64'(avm_if.avm_read), 64'd0);
    check("rst_addr",    64'(avm_if.avm_address), 64'd0);
    check("rst_valid",   64'(sample_valid), 64'd0);
    check("rst_changed", 64'(changed), 64'd0);
    check("rst_timeout", 64'(timeout), 64'd0);
    check("rst_sample",  64'(sample), 64'd0);
    check("rst_state",   64'(dbg.state), 64'(ST_IDLE));

    // Release; first poll POLL_DIV cycles later, constant 0x3A5.
    @(posedge clk); #1;
    reset = 1'b0; enable = 1'b1; avm_if.avm_readdata = 32'h3A5;
    last_start = cyc;
    exp_q.push_back({1'b1, 10'h3A5});
    wait_read("first_poll_gap", POLL_DIV);
    check("first_addr", 64'(avm_if.avm_address), 64'(RD_ADDR));
    exp_q.push_back({1'b0, 10'h3A5});
    go_idle(); start_poll(32'h0000_03A5, "poll2_gap", 8);

    // Upper bits set must not leak into sample.
    exp_q.push_back({1'b1, 10'h001});
    go_idle(); start_poll(32'hFFFF_FC01, "poll3_gap", 8);
    exp_q.push_back({1'b1, 10'h200});
    go_idle(); start_poll(32'hAAAA_AE00, "poll4_gap", 8);

    // Three stall cycles: read held 4 cycles, capture 2 cycles after accept.
    exp_q.push_back({1'b0, 10'h200});
    go_idle();
    avm_if.avm_readdata = 32'h0000_0200; avm_if.avm_waitrequest = 1'b1;
    wait_read("poll5_gap", 8);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("stall_read_held", 64'(avm_if.avm_read), 64'd1);
      check("stall_addr_held", 64'(avm_if.avm_address), 64'(RD_ADDR));
      if (i == 2) avm_if.avm_waitrequest = 1'b0;
    end
    @(posedge clk); #1;
    check("lat_read_low", 64'(avm_if.avm_read), 64'd0);
    check("lat_no_valid", 64'(sample_valid), 64'd0);
    @(posedge clk); #1;
    check("capt_valid",  64'(sample_valid), 64'd1);
    check("capt_sample", 64'(sample), 64'h200);
    @(posedge clk); #1;

    // Stalled forever: timeout after WAIT_MAX cycles, no capture.
    avm_if.avm_readdata = 32'h0000_00F0; avm_if.avm_waitrequest = 1'b1;
    wait_read("poll6_gap", 8);
    hi = 1;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #2;
      if (!avm_if.avm_read) break;
      hi++;
    end
    check("stall_cycles", 64'(hi), 64'(WAIT_MAX));
    check("timeout_set", 64'(timeout), 64'd1);
    avm_if.avm_waitrequest = 1'b0;
    exp_q.push_back({1'b1, 10'h0F0});
    wait_read("after_timeout_gap", 256);
    go_idle();
    check("timeout_sticky", 64'(timeout), 64'd1);

    // Enable dropped mid-READ: read completes, interval freezes 10 cycles.
    exp_q.push_back({1'b0, 10'h0F0});
    avm_if.avm_waitrequest = 1'b1;
    wait_read("poll8_gap", 8);
    enable = 1'b0;
    repeat (2) @(posedge clk);
    #1 avm_if.avm_waitrequest = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    enable = 1'b1; avm_if.avm_readdata = 32'hFFFF_F955;
    wait_read("disabled_gap", POLL_DIV + 10);

    // Reset during LAT: outputs clear at once, no capture.
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("rst_lat_read",    64'(avm_if.avm_read), 64'd0);
    check("rst_lat_addr",    64'(avm_if.avm_address), 64'd0);
    check("rst_lat_valid",   64'(sample_valid), 64'd0);
    check("rst_lat_changed", 64'(changed), 64'd0);
    check("rst_lat_timeout", 64'(timeout), 64'd0);
    check("rst_lat_sample",  64'(sample), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    last_start = cyc;
    exp_q.push_back({1'b1, 10'h155});
    wait_read("post_reset_gap", POLL_DIV);
    go_idle();
    check("no_timeout_after_reset", 64'(timeout), 64'd0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
